// File: rtl/cd2_pkg.sv
// cd2_pkg -- shared constants for the cd2 low-pulse width meter.
//   CNT_W_DEF       default width of the measurement counter / value output
//   SYNC_STAGES_DEF default depth of the input synchronizer
//   CNT_MAX         largest count representable at the default width
package cd2_pkg;
    localparam int CNT_W_DEF       = 12;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_MAX         = (1 << CNT_W_DEF) - 1;
endpackage

// File: rtl/cd2_sync.sv
// cd2_sync -- multi-flop synchronizer for one asynchronous level.
// All flops reset to 1 so an input already low at reset release is seen as
// a fresh falling edge downstream.
//   clk  : clock
//   rst  : synchronous active-high reset
//   d    : asynchronous input
//   q    : synchronized output (last flop of the chain)
module cd2_sync
    import cd2_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cd2.sv
// cd2 -- measures the width of low pulses on an asynchronous input A, in
// clk1 cycles, and presents each result with a one-cycle valid strobe.
//   clk1  : sole clock, rising edge
//   rst   : synchronous active-high reset (dominates everything)
//   A     : asynchronous level input
//   value : last measured low-pulse width (held between strobes)
//   valid : one-cycle strobe marking a new value
// Build option: define CD2_SAT_EN to make the counter saturate at its
// maximum instead of wrapping modulo 2^CNT_W.
module cd2
    import cd2_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             A,
    output logic [CNT_W-1:0] value,
    output logic             valid
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};

    logic             a_s;
    logic             a_p;
    logic             fall;
    logic             rise;
    logic [CNT_W-1:0] cnt;

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c);
`ifdef CD2_SAT_EN
        cnt_next = (c == CNT_TOP) ? c : c + CNT_ONE;
`else
        cnt_next = c + CNT_ONE;
`endif
    endfunction

    cd2_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk1),
        .rst (rst),
        .d   (A),
        .q   (a_s)
    );

    assign fall = ~a_s &  a_p;
    assign rise =  a_s & ~a_p;

    // Edge detect, counter and output registers
    always_ff @(posedge clk1) begin
        if (rst) begin
            a_p   <= 1'b1;
            cnt   <= '0;
            value <= '0;
            valid <= 1'b0;
        end else begin
            a_p   <= a_s;
            valid <= rise;
            if (rise) begin
                value <= cnt;
            end
            if (fall) begin
                cnt <= CNT_ONE;
            end else if (!a_s) begin
                cnt <= cnt_next(cnt);
            end
        end
    end

endmodule

// File: tb/tb_cd2.sv
module tb_cd2;

    localparam int S  = 2;
    localparam int CW = 12;

    logic          clk1 = 1'b0;
    logic          rst  = 1'b1;
    logic          A    = 1'b1;
    logic [CW-1:0] value;
    logic          valid;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    logic prev_valid = 1'b0;

    cd2 #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
        .clk1  (clk1),
        .rst   (rst),
        .A     (A),
        .value (value),
        .valid (valid)
    );

    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs must never be X and valid must never stay high two cycles.
    always @(negedge clk1) begin
        if (mon_en) begin
            n_checks++;
            assert (!$isunknown({value, valid}) && !(valid && prev_valid)) else begin
                n_fail++;
                $error("FAIL monitor: observed valid=%b prev=%b value=%0h expected no X, no double strobe",
                       valid, prev_valid, value);
            end
        end
        prev_valid <= valid;
    end

    // Low pulse of n clock-aligned cycles, then check strobe timing/value/hold.
    task automatic measure(input string tag, input int n, input int expv);
        A = 1'b0;
        repeat (n) begin
            tick();
            chk({tag, "_low_valid"}, 32'(valid), 32'd0);
        end
        A = 1'b1;
        for (int i = 1; i <= S; i++) begin
            tick();
            chk({tag, "_pre_valid"}, 32'(valid), 32'd0);
        end
        tick();
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_value"}, 32'(value), 32'(expv));
        tick();
        chk({tag, "_valid_drop"}, 32'(valid), 32'd0);
        chk({tag, "_hold"}, 32'(value), 32'(expv));
    endtask

    // Pulse with random phase against clk1; width is n clock periods.
    task automatic rand_pulse(input string tag, input int n);
        int off;
        bit found;
        off = $urandom_range(1, 9);
        @(posedge clk1);
        #(off);
        A = 1'b0;
        #(n * 10);
        A = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (valid) found = 1'b1;
        end
        chk({tag, "_strobe_seen"}, 32'(found), 32'd1);
        chk({tag, "_within1"},
            32'((int'(value) >= n - 1) && (int'(value) <= n + 1)), 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        int long_exp;
        int wrap_exp;
`ifdef CD2_SAT_EN
        long_exp = 4095;
        wrap_exp = 4095;
`else
        long_exp = 904;
        wrap_exp = 1;
`endif
        // Reset state
        rst = 1'b1;
        A   = 1'b1;
        repeat (3) tick();
        chk("reset_value", 32'(value), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        chk("idle_valid", 32'(valid), 32'd0);
        chk("idle_value", 32'(value), 32'd0);
        mon_en = 1'b1;

        measure("low10", 10, 10);
        repeat (3) tick();
        measure("low1", 1, 1);
        repeat (3) tick();

        // 3, 7, 100 separated by 5 high cycles (4 inside measure + 1)
        measure("seq3", 3, 3);
        tick();
        chk("seq3_held", 32'(value), 32'd3);
        measure("seq7", 7, 7);
        tick();
        chk("seq7_held", 32'(value), 32'd7);
        measure("seq100", 100, 100);
        repeat (3) tick();

        measure("long5000", 5000, long_exp);
        repeat (3) tick();
        measure("wrap4097", 4097, wrap_exp);
        repeat (3) tick();

        // A already low when reset releases is a new pulse
        rst = 1'b1;
        A   = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        measure("rstlow20", 20, 20);
        repeat (3) tick();

        // Reset mid-pulse discards the measurement
        A = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        A   = 1'b1;
        tick();
        chk("midrst_value", 32'(value), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < S + 4; i++) begin
            tick();
            chk("midrst_no_strobe", 32'(valid), 32'd0);
        end
        chk("midrst_value_after", 32'(value), 32'd0);

        // Asynchronous phase
        rand_pulse("rnd5", 5);
        rand_pulse("rnd13", 13);
        rand_pulse("rnd2", 2);
        rand_pulse("rnd40", 40);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
